// File: rtl/io_axi_local_window_pkg.sv
// rtl/io_axi_local_window_pkg.sv - shared types for the IO AXI local window splitter
// Purpose: register index enum, AXI response codes and the two window FSM state enums.
// Ports: none (package).
package io_axi_local_window_pkg;

    typedef enum logic [1:0] {
        REG_THREAD_EN = 2'd0,
        REG_RESUME    = 2'd1,
        REG_SUSPEND   = 2'd2,
        REG_SCRATCH   = 2'd3
    } local_reg_idx_t;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t AXI_OKAY   = 2'b00;
    localparam axi_resp_t AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_LOCAL, W_PASS} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOCAL, R_PASS} rd_state_t;

endpackage

// File: rtl/io_axi_local_window_regfile.sv
// rtl/io_axi_local_window_regfile.sv - local thread-control registers behind the window
// Purpose: THREAD_EN/SCRATCH storage, byte-strobe merge, RESUME/SUSPEND side effects,
//          core resume/suspend merge into thread_en, and the combinational read mux.
// Ports: clk, reset; wr_en/wr_idx/wr_data/wr_strb write port; rd_idx -> rd_data read port;
//        core_resume_mask/core_suspend_mask in; thread_en out.
module io_axi_local_regfile
    import io_axi_local_window_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int TOTAL_THREADS = 4,
    parameter int IDX_W         = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DATA_WIDTH/8-1:0]    wr_strb,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic [TOTAL_THREADS-1:0]   core_resume_mask,
    input  logic [TOTAL_THREADS-1:0]   core_suspend_mask,
    output logic [TOTAL_THREADS-1:0]   thread_en
);

    logic [TOTAL_THREADS-1:0] thread_en_q, thread_en_d;
    logic [DATA_WIDTH-1:0]    scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0]    bmask;
    logic [TOTAL_THREADS-1:0] wbits;
    logic                     wr_thread, wr_resume, wr_suspend, wr_scratch;

    always_comb begin
        bmask = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            bmask[8*i +: 8] = {8{wr_strb[i]}};
        end
    end

    assign wr_thread  = wr_en && (wr_idx == IDX_W'(REG_THREAD_EN));
    assign wr_resume  = wr_en && (wr_idx == IDX_W'(REG_RESUME));
    assign wr_suspend = wr_en && (wr_idx == IDX_W'(REG_SUSPEND));
    assign wr_scratch = wr_en && (wr_idx == IDX_W'(REG_SCRATCH));

    // Strobe-qualified write bits shared by THREAD_EN merge, W1S and W1C.
    assign wbits = wr_data[TOTAL_THREADS-1:0] & bmask[TOTAL_THREADS-1:0];

    // Order matters: the core suspend mask is applied last so it wins over every source.
    always_comb begin
        thread_en_d = thread_en_q;
        if (wr_thread) begin
            thread_en_d = (thread_en_q & ~bmask[TOTAL_THREADS-1:0]) | wbits;
        end
        if (wr_resume) begin
            thread_en_d = thread_en_d | wbits;
        end
        if (wr_suspend) begin
            thread_en_d = thread_en_d & ~wbits;
        end
        thread_en_d = (thread_en_d | core_resume_mask) & ~core_suspend_mask;
    end

    always_comb begin
        scratch_d = scratch_q;
        if (wr_scratch) begin
            scratch_d = (scratch_q & ~bmask) | (wr_data & bmask);
        end
    end

    // Reads see the registered values, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data = '0;
        if (rd_idx == IDX_W'(REG_THREAD_EN)) begin
            rd_data = DATA_WIDTH'(thread_en_q);
        end else if (rd_idx == IDX_W'(REG_SCRATCH)) begin
            rd_data = scratch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thread_en_q <= TOTAL_THREADS'(1);
            scratch_q   <= '0;
        end else begin
            thread_en_q <= thread_en_d;
            scratch_q   <= scratch_d;
        end
    end

    assign thread_en = thread_en_q;

endmodule

// File: rtl/io_axi_local_window.sv
// rtl/io_axi_local_window.sv - AXI4-Lite splitter: local register window or external pass-through
// Purpose: accesses whose masked address equals WINDOW_BASE go to the local register file,
//          all others pass to the m_* port with one outstanding transaction per direction.
// Ports: clk, reset; s_aw*/s_w*/s_b*/s_ar*/s_r* slave side from io_interconnect;
//        m_* mirrored master side to the external IO port; core_resume_mask,
//        core_suspend_mask in; thread_en out.
module io_axi_local_window
    import io_axi_local_window_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_BASE   = 'h5000,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_MASK   = 'hF000,
    parameter int                    NUM_REGS      = 4,
    parameter int                    TOTAL_THREADS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [DATA_WIDTH-1:0]    s_wdata,
    input  logic [DATA_WIDTH/8-1:0]  s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [DATA_WIDTH-1:0]    s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [ADDR_WIDTH-1:0]    m_awaddr,
    output logic [2:0]               m_awprot,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_wstrb,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic [1:0]               m_bresp,
    input  logic                     m_bvalid,
    output logic                     m_bready,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic [2:0]               m_arprot,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    input  logic [TOTAL_THREADS-1:0] core_resume_mask,
    input  logic [TOTAL_THREADS-1:0] core_suspend_mask,
    output logic [TOTAL_THREADS-1:0] thread_en
);

    localparam int               IDX_W      = $clog2(NUM_REGS) + 1;
    localparam logic [IDX_W-1:0] NUM_REGS_I = IDX_W'(NUM_REGS);

    wr_state_t             wr_state_q, wr_state_d;
    rd_state_t             rd_state_q, rd_state_d;
    axi_resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, reg_rd_data;
    logic                  aw_hit, ar_hit, aw_err, ar_err, reg_wr_en;
    logic [IDX_W-1:0]      aw_idx, ar_idx;

    assign aw_hit = (s_awaddr & WINDOW_MASK) == WINDOW_BASE;
    assign ar_hit = (s_araddr & WINDOW_MASK) == WINDOW_BASE;
    assign aw_idx = s_awaddr[2 +: IDX_W];
    assign ar_idx = s_araddr[2 +: IDX_W];
    assign aw_err = aw_idx >= NUM_REGS_I;
    assign ar_err = ar_idx >= NUM_REGS_I;

    // Payloads always flow through; only the valids are gated by the FSMs.
    assign m_awaddr = s_awaddr;
    assign m_awprot = s_awprot;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
    assign m_araddr = s_araddr;
    assign m_arprot = s_arprot;

    io_axi_local_regfile #(
        .DATA_WIDTH    (DATA_WIDTH),
        .TOTAL_THREADS (TOTAL_THREADS),
        .IDX_W         (IDX_W)
    ) u_regfile (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (reg_wr_en),
        .wr_idx            (aw_idx),
        .wr_data           (s_wdata),
        .wr_strb           (s_wstrb),
        .rd_idx            (ar_idx),
        .rd_data           (reg_rd_data),
        .core_resume_mask  (core_resume_mask),
        .core_suspend_mask (core_suspend_mask),
        .thread_en         (thread_en)
    );

    // Write path. w_done tracks a forwarded W beat that completed before or with AW.
    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        w_done_d   = w_done_q;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        s_bresp    = bresp_q;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        reg_wr_en  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s_awvalid && aw_hit) begin
                    // Local writes need AW and W together; nothing leaks to m_*.
                    if (s_wvalid) begin
                        s_awready  = 1'b1;
                        s_wready   = 1'b1;
                        reg_wr_en  = !aw_err;
                        bresp_d    = aw_err ? AXI_SLVERR : AXI_OKAY;
                        wr_state_d = W_LOCAL;
                    end
                end else if (s_awvalid) begin
                    m_awvalid = 1'b1;
                    s_awready = m_awready;
                    m_wvalid  = s_wvalid && !w_done_q;
                    s_wready  = m_wready && !w_done_q;
                    w_done_d  = w_done_q || (m_wvalid && m_wready);
                    if (m_awready) begin
                        wr_state_d = W_PASS;
                    end
                end
            end
            W_LOCAL: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            W_PASS: begin
                m_wvalid = s_wvalid && !w_done_q;
                s_wready = m_wready && !w_done_q;
                w_done_d = w_done_q || (m_wvalid && m_wready);
                s_bvalid = m_bvalid;
                s_bresp  = m_bresp;
                m_bready = s_bready;
                if (m_bvalid && s_bready) begin
                    wr_state_d = W_IDLE;
                    w_done_d   = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = rdata_q;
        s_rresp    = rresp_q;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_arvalid && ar_hit) begin
                    s_arready  = 1'b1;
                    rdata_d    = reg_rd_data;
                    rresp_d    = ar_err ? AXI_SLVERR : AXI_OKAY;
                    rd_state_d = R_LOCAL;
                end else if (s_arvalid) begin
                    m_arvalid = 1'b1;
                    s_arready = m_arready;
                    if (m_arready) begin
                        rd_state_d = R_PASS;
                    end
                end
            end
            R_LOCAL: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            R_PASS: begin
                s_rvalid = m_rvalid;
                s_rdata  = m_rdata;
                s_rresp  = m_rresp;
                m_rready = s_rready;
                if (m_rvalid && s_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            bresp_q    <= AXI_OKAY;
            rresp_q    <= AXI_OKAY;
            w_done_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_io_axi_local_window.sv
// tb/tb_io_axi_local_window.sv - directed table-driven bench for io_axi_local_window
module tb_io_axi_local_window;

    logic        clk, reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot, m_awprot, m_arprot;
    logic [3:0]  s_wstrb, m_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  core_resume_mask, core_suspend_mask, thread_en;

    io_axi_local_window dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .core_resume_mask(core_resume_mask), .core_suspend_mask(core_suspend_mask),
        .thread_en(thread_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  cres;
        logic [3:0]  csus;
        logic [1:0]  eresp;
        logic [31:0] erdata;
        logic [3:0]  ethr;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic local_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic hs, output logic bv, output logic [1:0] resp);
        s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; s_bready = 1'b1;
        #1 hs = s_awready & s_wready & ~m_awvalid & ~m_wvalid;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1 bv = s_bvalid; resp = s_bresp;
        tick();
    endtask

    task automatic local_read(input logic [31:0] a, output logic hs, output logic rv,
                              output logic [1:0] resp, output logic [31:0] data);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        #1 hs = s_arready & ~m_arvalid;
        tick();
        s_arvalid = 1'b0;
        #1 rv = s_rvalid; resp = s_rresp; data = s_rdata;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        hs, vv;
        logic [1:0]  resp;
        logic [31:0] data;

        vecs[0]  = '{1'b1, 32'h5000, 32'hF,        4'hF, 4'h0, 4'h0, 2'b00, 32'h0,        4'hF};
        vecs[1]  = '{1'b1, 32'h5000, 32'h1,        4'hF, 4'h0, 4'h0, 2'b00, 32'h0,        4'h1};
        vecs[2]  = '{1'b1, 32'h500C, 32'hA5A51234, 4'h5, 4'h0, 4'h0, 2'b00, 32'h0,        4'h1};
        vecs[3]  = '{1'b0, 32'h500C, 32'h0,        4'h0, 4'h0, 4'h0, 2'b00, 32'h00A50034, 4'h1};
        vecs[4]  = '{1'b1, 32'h5004, 32'h6,        4'hF, 4'h0, 4'h2, 2'b00, 32'h0,        4'h5};
        vecs[5]  = '{1'b0, 32'h5004, 32'h0,        4'h0, 4'h0, 4'h0, 2'b00, 32'h0,        4'h5};
        vecs[6]  = '{1'b1, 32'h5008, 32'h4,        4'h1, 4'h0, 4'h0, 2'b00, 32'h0,        4'h1};
        vecs[7]  = '{1'b1, 32'h5008, 32'h1,        4'h0, 4'h0, 4'h0, 2'b00, 32'h0,        4'h1};
        vecs[8]  = '{1'b0, 32'h5000, 32'h0,        4'h0, 4'h0, 4'h0, 2'b00, 32'h1,        4'h1};
        vecs[9]  = '{1'b1, 32'h5000, 32'hE,        4'hF, 4'h1, 4'h0, 2'b00, 32'h0,        4'hF};
        vecs[10] = '{1'b1, 32'h5010, 32'hFF,       4'hF, 4'h0, 4'h0, 2'b10, 32'h0,        4'hF};
        vecs[11] = '{1'b0, 32'h5010, 32'h0,        4'h0, 4'h0, 4'h0, 2'b10, 32'h0,        4'hF};
        vecs[12] = '{1'b0, 32'h5014, 32'h0,        4'h0, 4'h0, 4'h0, 2'b10, 32'h0,        4'hF};
        vecs[13] = '{1'b0, 32'h500C, 32'h0,        4'h0, 4'h0, 4'h0, 2'b00, 32'h00A50034, 4'hF};
        vecs[14] = '{1'b1, 32'h5000, 32'h3,        4'hF, 4'h1, 4'h1, 2'b00, 32'h0,        4'h2};
        vecs[15] = '{1'b1, 32'h5000, 32'hF,        4'h0, 4'h0, 4'h0, 2'b00, 32'h0,        4'h2};
        vecs[16] = '{1'b0, 32'h5000, 32'h0,        4'h0, 4'h0, 4'h0, 2'b00, 32'h2,        4'h2};

        reset = 1'b1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0; m_arready = 0;
        m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        core_resume_mask = '0; core_suspend_mask = '0;
        tick(); tick();
        #1;
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_thread_en", thread_en, 4'h1);
        check("rst_readies", {s_awready, s_wready, s_arready}, 0);
        check("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        reset = 1'b0;
        tick();

        // Local register vectors
        for (int i = 0; i < 17; i++) begin
            core_resume_mask = vecs[i].cres;
            core_suspend_mask = vecs[i].csus;
            if (vecs[i].wr) begin
                local_write(vecs[i].addr, vecs[i].data, vecs[i].strb, hs, vv, resp);
                check($sformatf("v%0d_wr_handshake", i), hs, 1);
                check($sformatf("v%0d_bvalid", i), vv, 1);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].eresp);
            end else begin
                local_read(vecs[i].addr, hs, vv, resp, data);
                check($sformatf("v%0d_rd_handshake", i), hs, 1);
                check($sformatf("v%0d_rvalid", i), vv, 1);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].eresp);
                check($sformatf("v%0d_rdata", i), data, vecs[i].erdata);
            end
            #1 check($sformatf("v%0d_thread_en", i), thread_en, vecs[i].ethr);
            core_resume_mask = '0;
            core_suspend_mask = '0;
            tick();
        end

        // Local read held with rready low
        s_araddr = 32'h5000; s_arvalid = 1; s_rready = 0;
        #1 check("hold_arready", s_arready, 1);
        tick();
        s_arvalid = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("hold_rvalid_%0d", k), s_rvalid, 1);
            check($sformatf("hold_rdata_%0d", k), s_rdata, 32'h2);
            tick();
        end
        s_rready = 1;
        #1 check("hold_rvalid_last", s_rvalid, 1);
        tick();
        #1 check("hold_rvalid_drop", s_rvalid, 0);
        tick();

        // Same-cycle read and write of SCRATCH returns the old value
        s_awaddr = 32'h500C; s_awvalid = 1; s_wdata = 32'h11223344; s_wstrb = 4'hF; s_wvalid = 1;
        s_bready = 1; s_araddr = 32'h500C; s_arvalid = 1; s_rready = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        #1 check("rw_rvalid", s_rvalid, 1);
        check("rw_old_rdata", s_rdata, 32'h00A50034);
        check("rw_bvalid", s_bvalid, 1);
        tick();
        local_read(32'h500C, hs, vv, resp, data);
        check("rw_new_rdata", data, 32'h11223344);

        // AW hit waiting on W
        m_awready = 1; m_wready = 1;
        s_awaddr = 32'h500C; s_awvalid = 1; s_wvalid = 0; s_bready = 1;
        for (int k = 0; k < 2; k++) begin
            #1 check($sformatf("wwait_readies_%0d", k), {s_awready, s_wready}, 0);
            check($sformatf("wwait_m_valids_%0d", k), {m_awvalid, m_wvalid}, 0);
            tick();
        end
        s_wvalid = 1; s_wdata = 32'h77; s_wstrb = 4'hF;
        #1 check("wwait_hs", {s_awready, s_wready, m_awvalid, m_wvalid}, 4'b1100);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        #1 check("wwait_bvalid", {s_bvalid, s_bresp}, 3'b100);
        tick();
        m_awready = 0; m_wready = 0;
        local_read(32'h500C, hs, vv, resp, data);
        check("wwait_scratch", data, 32'h77);

        // Pass-through write with a blocked second AW
        s_awaddr = 32'h1000; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
        s_bready = 1; m_awready = 1; m_wready = 1;
        #1 check("pw_m_aw", {m_awvalid, m_awaddr}, {1'b1, 32'h1000});
        check("pw_m_w", {m_wvalid, m_wdata}, {1'b1, 32'hDEADBEEF});
        check("pw_s_readies", {s_awready, s_wready}, 2'b11);
        tick();
        s_awaddr = 32'h2000; s_awvalid = 1; s_wvalid = 0;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("pw_stall_%0d", k), {s_awready, m_awvalid, s_bvalid}, 0);
            tick();
        end
        m_bvalid = 1; m_bresp = 2'b10;
        #1 check("pw_b_fwd", {s_bvalid, s_bresp, m_bready, s_awready}, 5'b11010);
        tick();
        m_bvalid = 0;
        #1 check("pw2_aw", {m_awvalid, m_awaddr, s_awready, m_wvalid}, {1'b1, 32'h2000, 1'b1, 1'b0});
        tick();
        s_awvalid = 0; s_wvalid = 1; s_wdata = 32'h55;
        #1 check("pw2_w_late", {m_wvalid, s_wready, m_wdata}, {1'b1, 1'b1, 32'h55});
        tick();
        s_wvalid = 0; m_bvalid = 1; m_bresp = 2'b00;
        #1 check("pw2_b", {s_bvalid, s_bresp, m_wvalid}, 4'b1000);
        tick();
        m_bvalid = 0; m_awready = 0; m_wready = 0;
        #1 check("pw2_idle", {s_bvalid, m_bready}, 0);

        // Pass-through read
        s_araddr = 32'h3000; s_arvalid = 1; m_arready = 1; s_rready = 1;
        #1 check("pr_ar", {m_arvalid, m_araddr, s_arready, s_rvalid}, {1'b1, 32'h3000, 1'b1, 1'b0});
        tick();
        s_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
        #1 check("pr_r", {s_rvalid, s_rdata, m_rready}, {1'b1, 32'hCAFEF00D, 1'b1});
        tick();
        m_rvalid = 0;
        #1 check("pr_idle", {s_rvalid, m_rready}, 0);

        // Reset during W_PASS and R_LOCAL
        s_awaddr = 32'h1000; s_awvalid = 1; s_wvalid = 1; m_awready = 1; m_wready = 1; s_bready = 0;
        s_araddr = 32'h5000; s_arvalid = 1; s_rready = 0;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1;
        #1 check("pre_rst_states", {m_bready, s_rvalid}, 2'b11);
        reset = 1;
        tick();
        #1 check("mid_rst_valids", {s_bvalid, s_rvalid, m_bready, m_rready}, 0);
        check("mid_rst_thread_en", thread_en, 4'h1);
        reset = 0;
        tick();
        #1 check("post_rst_idle", {s_bvalid, s_rvalid, m_bready}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
